// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
// Kept separate so a future uart_tx can import the same package.
package lib_uart;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } RX_STATE;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 (idle line).
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding the CPU input port.
// Ports: clk, reset (sync, active-high), rx (async serial, idle high), ack (CPU level ack),
//        irr (byte available, held until ack), r_data (byte), overrun (sticky), frame_err (1-cycle pulse).
module uart_rx
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ack,
    output logic       irr,
    output logic [7:0] r_data,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    RX_STATE              state;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 deliver;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick    = (state != IDLE) && (cnt == '0);
    assign deliver = tick && (state == STOP) && rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            irr       <= 1'b0;
            r_data    <= 8'h00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // A new byte wins over a same-cycle ack: irr stays up for it.
            if (deliver) begin
                r_data <= shift;
                irr    <= 1'b1;
                if (irr && !ack)
                    overrun <= 1'b1;
            end else if (ack) begin
                irr <= 1'b0;
            end

            if (state != IDLE && !tick)
                cnt <= cnt - 1'b1;

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            cnt   <= FULL;
                            idx   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        cnt   <= FULL;
                        if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        // Even parity: the parity bit equals the XOR of the data.
                        if (rx_s != ^shift) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= STOP;
                            cnt   <= FULL;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        if (!rx_s)
                            frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed literal checks.
// Optional parity build is exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPB = 16;
    // Edge index of a frame's stop/parity decision relative to the first edge sampling the start bit.
    localparam int DEC_OFS = 10 + 16 * 9;
`ifdef UART_RX_PARITY_EN
    localparam int NFULL = 11;
`else
    localparam int NFULL = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ack = 1'b0;
    logic       irr;
    logic [7:0] r_data;
    logic       overrun;
    logic       frame_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .ack       (ack),
        .irr       (irr),
        .r_data    (r_data),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit       err;
        logic [7:0] data;
    } ev_t;

    ev_t evq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit started = 0;
    bit ack_rand = 0;

    logic       m_irr = 0;
    logic [7:0] m_data = 0;
    logic       m_ovr = 0;
    logic       m_fe = 0;

    int last_n0 = 0;
    int rise_cyc = 0;
    int irr_rises = 0;
    int fe_cycles = 0;
    logic prev_irr = 0;

    // Frame-level reference: each completed frame is one scheduled event.
    always @(posedge clk) begin
        ev_t e;
        bit hit;
        cyc = cyc + 1;
        started = 1;
        if (reset) begin
            m_irr = 0;
            m_data = 0;
            m_ovr = 0;
            m_fe = 0;
            evq.delete();
        end else begin
            m_fe = 0;
            hit = 0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                hit = 1;
            end
            if (hit && e.err) m_fe = 1;
            if (hit && !e.err) begin
                if (m_irr && !ack) m_ovr = 1;
                m_irr = 1;
                m_data = e.data;
            end else if (ack) begin
                m_irr = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (irr !== m_irr || r_data !== m_data ||
                overrun !== m_ovr || frame_err !== m_fe) begin
                failures++;
                $display("FAIL model cyc=%0d actual irr=%b data=%h ovr=%b fe=%b required irr=%b data=%h ovr=%b fe=%b",
                         cyc, irr, r_data, overrun, frame_err, m_irr, m_data, m_ovr, m_fe);
            end
            if (irr === 1'b1 && prev_irr === 1'b0) begin
                rise_cyc = cyc;
                irr_rises++;
            end
            if (frame_err === 1'b1) fe_cycles++;
            prev_irr = irr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ack_rand) ack = ($urandom_range(0, 9) == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        rx = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
    endtask

    // Drives nb bits of a frame; full frames schedule their outcome in the model.
    task automatic send(input logic [7:0] d, input logic stop, input logic par,
                        input int nb, input bit ack_del);
        logic bits [0:10];
        int n0;
        int evc;
        ev_t e;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
        bits[9] = par;
        bits[10] = stop;
`else
        bits[9] = stop;
        bits[10] = 1'b1;
`endif
        @(posedge clk); #1;
        n0 = cyc;
        last_n0 = n0;
        e.data = d;
`ifdef UART_RX_PARITY_EN
        if (par != ^d) begin
            evc = n0 + 1 + DEC_OFS;
            e.err = 1;
        end else begin
            evc = n0 + 1 + DEC_OFS + 16;
            e.err = !stop;
        end
`else
        evc = n0 + 1 + DEC_OFS;
        e.err = !stop;
`endif
        e.cyc = evc;
        if (nb == NFULL) evq.push_back(e);
        for (int t = 0; t < nb * 16; t++) begin
            rx = bits[t / 16];
            if (ack_del) ack = (n0 + t == evc - 1);
            @(posedge clk); #1;
        end
        rx = 1;
        if (ack_del) ack = 0;
        if (nb == NFULL) begin
            repeat (40) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        ack = 1;
        @(posedge clk); #1;
        ack = 0;
    endtask

    initial begin
        int fe0;
        int rises0;
        logic [7:0] d;
        logic st;
        logic p;

        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("reset_irr", {31'b0, irr}, 0);
        chk("reset_data", {24'b0, r_data}, 32'h00);
        chk("reset_ovr", {31'b0, overrun}, 0);
        chk("reset_fe", {31'b0, frame_err}, 0);

        send(8'hA5, 1, 0, NFULL, 0);
`ifdef UART_RX_PARITY_EN
        chk("latency", rise_cyc - (last_n0 + 1), 170);
`else
        chk("latency", rise_cyc - (last_n0 + 1), 154);
`endif
        chk("a5_irr", {31'b0, irr}, 1);
        chk("a5_data", {24'b0, r_data}, 32'hA5);
        chk("a5_ovr", {31'b0, overrun}, 0);
        pulse_ack();
        chk("ack_clear", {31'b0, irr}, 0);

        send(8'h3C, 1, 0, NFULL, 0);
        chk("3c_irr", {31'b0, irr}, 1);
        chk("3c_data", {24'b0, r_data}, 32'h3C);
        pulse_ack();

        fe0 = fe_cycles;
        rx = 0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_irr", {31'b0, irr}, 0);
        chk("glitch_fe", fe_cycles - fe0, 0);

        fe0 = fe_cycles;
        send(8'h55, 0, 0, NFULL, 0);
        chk("stop0_fe_cycles", fe_cycles - fe0, 1);
        chk("stop0_irr", {31'b0, irr}, 0);
        chk("stop0_data", {24'b0, r_data}, 32'h3C);

        send(8'h11, 1, 0, NFULL, 0);
        send(8'h22, 1, 0, NFULL, 0);
        chk("ovr_irr", {31'b0, irr}, 1);
        chk("ovr_data", {24'b0, r_data}, 32'h22);
        chk("ovr_flag", {31'b0, overrun}, 1);

        do_reset();
        send(8'h11, 1, 0, NFULL, 0);
        send(8'h22, 1, 0, NFULL, 1);
        chk("ackdel_irr", {31'b0, irr}, 1);
        chk("ackdel_data", {24'b0, r_data}, 32'h22);
        chk("ackdel_ovr", {31'b0, overrun}, 0);

        send(8'hFF, 1, 1, 4, 0);
        fe0 = fe_cycles;
        do_reset();
        rises0 = irr_rises;
        repeat (20) @(posedge clk);
        #1;
        send(8'h0F, 1, 0, NFULL, 0);
        chk("midrst_rises", irr_rises - rises0, 1);
        chk("midrst_data", {24'b0, r_data}, 32'h0F);
        chk("midrst_fe", fe_cycles - fe0, 0);
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        fe0 = fe_cycles;
        send(8'h07, 1, 0, NFULL, 0);
        chk("par_fe", fe_cycles - fe0, 1);
        chk("par_irr", {31'b0, irr}, 0);
`endif

        ack_rand = 1;
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            p = ^d;
            if ($urandom_range(0, 5) == 0) p = ~p;
            send(d, st, p, NFULL, 0);
        end
        ack_rand = 0;
        ack = 0;
        repeat (10) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
